// File: rtl/ghost_wall_server.sv
// ghost_wall_server: looks up the four maze neighbours of each of four ghosts
// and publishes the 16 resulting wall flags in a single atomic update.
module ghost_wall_server #(
    parameter int MAZE_W   = 28,
    parameter int MAZE_H   = 36,
    parameter int TUNNEL_Y = 19,
    parameter int DOOR_X   = 13,
    parameter int DOOR_Y   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] ghost_x,
    input  logic [23:0] ghost_y,
    output logic [9:0]  rom_addr,
    output logic        rom_rd,
    input  logic        rom_data,
    output logic [15:0] wall_flags,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    localparam logic [5:0] W6   = 6'(MAZE_W);
    localparam logic [5:0] H6   = 6'(MAZE_H);
    localparam logic [5:0] XMAX = 6'(MAZE_W - 1);
    localparam logic [5:0] YMAX = 6'(MAZE_H - 1);
    localparam logic [5:0] TY6  = 6'(TUNNEL_Y);
    localparam logic [5:0] DX6  = 6'(DOOR_X);
    localparam logic [5:0] DY6  = 6'(DOOR_Y);
    localparam logic [9:0] W10  = 10'(MAZE_W);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d, n;
    logic [23:0] gx_q, gx_d, gy_q, gy_d, src_x, src_y;
    logic [15:0] shadow_q, shadow_d, flags_q, flags_d;
    logic [9:0]  addr_q, addr_d, lk_addr;
    logic        rd_q, rd_d, use_q, use_d, val_q, val_d, done_q, done_d;
    logic [5:0]  x, y, nx, ny;
    logic [1:0]  d;
    logic        bad, edge_hit, door, forced, issue;

    // Lookup n is prepared combinationally and registered onto the ROM port;
    // the first lookup reads the live inputs since the snapshot lands on the same edge.
    always_comb begin
        n        = state_q == SCAN ? idx_q + 4'd1 : 4'd0;
        src_x    = state_q == SCAN ? gx_q : ghost_x;
        src_y    = state_q == SCAN ? gy_q : ghost_y;
        d        = n[1:0];
        x        = src_x[int'(n[3:2]) * 6 +: 6];
        y        = src_y[int'(n[3:2]) * 6 +: 6];
        bad      = x >= W6 || y >= H6;
        edge_hit = d == 2'd0 ? y == 6'd0 : d == 2'd1 ? y == YMAX : d == 2'd2 ? x == 6'd0 : x == XMAX;
        forced   = bad || edge_hit;
        nx       = d == 2'd2 ? x - 6'd1 : d == 2'd3 ? x + 6'd1 : x;
        ny       = d == 2'd0 ? y - 6'd1 : d == 2'd1 ? y + 6'd1 : y;
        door     = !d[1] && nx == DX6 && ny == DY6;
        lk_addr  = {4'd0, ny} * W10 + {4'd0, nx};
        issue    = (state_q == IDLE && start) || (state_q == SCAN && idx_q != 4'd15);
        state_d  = state_q == IDLE ? (start ? SCAN : IDLE)
                 : state_q == SCAN ? (idx_q == 4'd15 ? COMMIT : SCAN) : IDLE;
        idx_d    = issue ? n : idx_q;
        gx_d     = state_q == IDLE && start ? ghost_x : gx_q;
        gy_d     = state_q == IDLE && start ? ghost_y : gy_q;
        rd_d     = issue && !forced;
        use_d    = issue && !forced && !door;
        val_d    = forced ? (bad || !d[1] || y != TY6) : d[0];
        addr_d   = rd_d ? lk_addr : addr_q;
        shadow_d = shadow_q;
        if (state_q == SCAN) shadow_d[idx_q] = use_q ? rom_data : val_q;
        flags_d  = state_q == COMMIT ? shadow_q : flags_q;
        done_d   = state_q == COMMIT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            gx_q     <= '0;
            gy_q     <= '0;
            shadow_q <= '0;
            flags_q  <= 16'hFFFF;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            use_q    <= 1'b0;
            val_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            shadow_q <= shadow_d;
            flags_q  <= flags_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            use_q    <= use_d;
            val_q    <= val_d;
            done_q   <= done_d;
        end
    end

    assign rom_addr   = addr_q;
    assign rom_rd     = rd_q;
    assign wall_flags = flags_q;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
endmodule

// File: tb/tb_ghost_wall_server.sv
// tb_ghost_wall_server: directed and random scans of ghost_wall_server checked
// against a per-tile maze model with a bench-side ROM.
module tb_ghost_wall_server;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [23:0] ghost_x = '0, ghost_y = '0;
    logic [9:0]  rom_addr;
    logic        rom_rd, rom_data, busy, done;
    logic [15:0] wall_flags;

    bit          mem [0:1007];
    int          total = 0, bad = 0;
    logic [15:0] cur_flags = 16'hFFFF, exp_flags;
    int          exp_rd [16];
    logic [9:0]  exp_addr [16];
    logic [19:0] restart_mask = '0;
    logic [23:0] gx, gy;

    ghost_wall_server dut (
        .clk(clk), .reset(reset), .start(start), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
        .wall_flags(wall_flags), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign rom_data = (rom_rd && rom_addr < 10'd1008) ? mem[rom_addr] : 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Maze rules on the default 28x36 maze, tunnel row 19, door (13,15).
    // exp_rd: 0 no read, 1 read at exp_addr, 2 door tile (read not checked).
    task automatic predict(input logic [23:0] px, input logic [23:0] py);
        for (int g = 0; g < 4; g++) begin
            for (int dd = 0; dd < 4; dd++) begin
                int x, y, nx, ny, i;
                bit f;
                x = int'(px[6*g +: 6]);
                y = int'(py[6*g +: 6]);
                i = 4*g + dd;
                exp_rd[i] = 0;
                exp_addr[i] = '0;
                if (x >= 28 || y >= 36) f = 1'b1;
                else if ((dd == 0 && y == 0) || (dd == 1 && y == 35)) f = 1'b1;
                else if ((dd == 2 && x == 0) || (dd == 3 && x == 27)) f = (y != 19);
                else begin
                    nx = x + (dd == 3 ? 1 : dd == 2 ? -1 : 0);
                    ny = y + (dd == 1 ? 1 : dd == 0 ? -1 : 0);
                    if (nx == 13 && ny == 15) begin
                        f = (dd == 1);
                        exp_rd[i] = 2;
                    end else begin
                        f = mem[ny*28 + nx];
                        exp_rd[i] = 1;
                        exp_addr[i] = 10'(ny*28 + nx);
                    end
                end
                exp_flags[i] = f;
            end
        end
    endtask

    function automatic logic [23:0] rnd_pack(input int hi);
        return {6'($urandom_range(0, hi)), 6'($urandom_range(0, hi)),
                6'($urandom_range(0, hi)), 6'($urandom_range(0, hi))};
    endfunction

    // Called at a negedge; start is accepted on the next posedge (edge 0) and
    // the task returns at the negedge after edge 17.
    task automatic run_scan(input logic [23:0] px, input logic [23:0] py, input string tag);
        ghost_x = px;
        ghost_y = py;
        start = 1'b1;
        predict(px, py);
        @(posedge clk);
        @(negedge clk);
        start = restart_mask[1];
        ghost_x = $urandom;
        ghost_y = $urandom;
        for (int k = 0; k < 16; k++) begin
            if (exp_rd[k] != 2) check($sformatf("%s rd%0d", tag, k), 32'(rom_rd), 32'(exp_rd[k]));
            if (exp_rd[k] == 1) check($sformatf("%s addr%0d", tag, k), 32'(rom_addr), 32'(exp_addr[k]));
            check($sformatf("%s busy%0d", tag, k), 32'(busy), 32'd1);
            check($sformatf("%s done%0d", tag, k), 32'(done), 32'd0);
            check($sformatf("%s hold%0d", tag, k), 32'(wall_flags), 32'(cur_flags));
            @(negedge clk);
            start = restart_mask[k+2];
        end
        check({tag, " busy16"}, 32'(busy), 32'd1);
        check({tag, " rd16"}, 32'(rom_rd), 32'd0);
        check({tag, " done16"}, 32'(done), 32'd0);
        check({tag, " hold16"}, 32'(wall_flags), 32'(cur_flags));
        @(negedge clk);
        start = 1'b0;
        check({tag, " done17"}, 32'(done), 32'd1);
        check({tag, " busy17"}, 32'(busy), 32'd0);
        check({tag, " rd17"}, 32'(rom_rd), 32'd0);
        check({tag, " flags"}, 32'(wall_flags), 32'(exp_flags));
        cur_flags = exp_flags;
    endtask

    task automatic idle_step(input string tag);
        @(negedge clk);
        check({tag, " idle_done"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1008; i++) mem[i] = 1'b0;
        mem[17*28 + 13] = 1'b1;
        repeat (2) @(negedge clk);
        check("rst flags", 32'(wall_flags), 32'hFFFF);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst rd", 32'(rom_rd), 32'd0);
        check("rst addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;

        gx = rnd_pack(27); gy = rnd_pack(35);
        gx[5:0] = 6'd13; gy[5:0] = 6'd16;
        run_scan(gx, gy, "door_up");
        check("door_up g0", 32'(wall_flags[3:0]), 32'b0010);
        idle_step("door_up");

        gx = rnd_pack(27); gy = rnd_pack(35);
        gx[11:6] = 6'd0; gy[11:6] = 6'd19;
        gx[17:12] = 6'd27; gy[17:12] = 6'd5;
        run_scan(gx, gy, "tunnel");
        check("tunnel g1 left", 32'(wall_flags[6]), 32'd0);
        check("tunnel g2 right", 32'(wall_flags[11]), 32'd1);
        idle_step("tunnel");

        mem[15*28 + 13] = 1'b1;
        gx = rnd_pack(27); gy = rnd_pack(35);
        gx[23:18] = 6'd13; gy[23:18] = 6'd16;
        run_scan(gx, gy, "door_ovr_up");
        check("door_ovr_up bit12", 32'(wall_flags[12]), 32'd0);
        idle_step("door_ovr_up");
        mem[15*28 + 13] = 1'b0;
        gy[23:18] = 6'd14;
        run_scan(gx, gy, "door_ovr_dn");
        check("door_ovr_dn bit13", 32'(wall_flags[13]), 32'd1);
        idle_step("door_ovr_dn");

        gx = rnd_pack(27); gy = rnd_pack(35);
        gx[5:0] = 6'd40; gy[5:0] = 6'd2;
        run_scan(gx, gy, "offmap");
        check("offmap g0", 32'(wall_flags[3:0]), 32'hF);
        idle_step("offmap");

        restart_mask = (20'd1 << 5) | (20'd1 << 17);
        run_scan(rnd_pack(27), rnd_pack(35), "restart_a");
        restart_mask = '0;
        run_scan(rnd_pack(27), rnd_pack(35), "restart_b");
        idle_step("restart_b");

        for (int i = 0; i < 1008; i++) mem[i] = ($urandom_range(0, 9) < 3);
        for (int r = 0; r < 6; r++) begin
            run_scan(rnd_pack(29), rnd_pack(37), $sformatf("rand%0d", r));
            idle_step($sformatf("rand%0d", r));
        end

        ghost_x = rnd_pack(27);
        ghost_y = rnd_pack(35);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort flags", 32'(wall_flags), 32'hFFFF);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort rd", 32'(rom_rd), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cur_flags = 16'hFFFF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("abort quiet done%0d", k), 32'(done), 32'd0);
        end
        check("abort quiet flags", 32'(wall_flags), 32'hFFFF);
        run_scan(rnd_pack(27), rnd_pack(35), "after_abort");
        idle_step("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ghost_wall_server.md
GHOST_WALL_SERVER -- requirements
Module: ghost_wall_server

Interface
REQ-001 SHALL have parameter MAZE_W, default 28, maze width in tiles.
REQ-002 SHALL have parameter MAZE_H, default 36, maze height in tiles.
REQ-003 SHALL have parameter TUNNEL_Y, default 19, row whose horizontal edges wrap.
REQ-004 SHALL have parameters DOOR_X, default 13, and DOOR_Y, default 15, giving the ghost-house door tile.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to refresh all wall flags (driven by the 60 Hz move tick).
REQ-008 SHALL have port ghost_x, input, 24, four packed 6-bit tile X values; ghost g occupies bits [6g+5:6g].
REQ-009 SHALL have port ghost_y, input, 24, four packed 6-bit tile Y values, same packing.
REQ-010 SHALL have port rom_addr, output, 10, maze ROM address = y*MAZE_W + x.
REQ-011 SHALL have port rom_rd, output, 1, ROM read enable.
REQ-012 SHALL have port rom_data, input, 1, ROM wall bit (1 = wall), valid one cycle after rom_rd.
REQ-013 SHALL have port wall_flags, output, 16, bit 4g+d = wall for ghost g, direction d (0 up, 1 down, 2 left, 3 right).
REQ-014 SHALL have port busy, output, 1, high while a scan is in progress.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when wall_flags has been updated.

Function
REQ-016 SHALL use FSM states IDLE, SCAN, COMMIT; IDLE->SCAN on start, SCAN->COMMIT after lookup 15 issues, COMMIT->IDLE after one cycle.
REQ-017 SHALL snapshot ghost_x and ghost_y on the edge that accepts start (edge 0); later input changes SHALL not affect that scan.
REQ-018 SHALL perform exactly 16 lookups in order i = 4g+d, g 0..3, d 0..3; lookup i is presented during the cycle after edge i and its result captured at edge i+1.
REQ-019 SHALL, for a ROM lookup, drive rom_rd=1 and rom_addr = neighbour_y*MAZE_W + neighbour_x; neighbours are up (x,y-1), down (x,y+1), left (x-1,y), right (x+1,y).
REQ-020 SHALL force a result without a ROM read (rom_rd=0) for: up with y=0 -> wall; down with y=MAZE_H-1 -> wall.
REQ-021 SHALL force left with x=0 and right with x=MAZE_W-1 to open (0) when y=TUNNEL_Y, otherwise to wall (1), with rom_rd=0.
REQ-022 SHALL force all four flags of a ghost to wall, with rom_rd=0, when its snapshot x>=MAZE_W or y>=MAZE_H.
REQ-023 SHALL treat the door neighbour (DOOR_X,DOOR_Y) as open for direction up and as wall for direction down, overriding rom_data.
REQ-024 SHALL accumulate results in a shadow register and copy all 16 bits to wall_flags atomically at edge 17; wall_flags SHALL never show a partial scan.
REQ-025 SHALL assert done for exactly the cycle after edge 17 and deassert busy at edge 17.
REQ-026 SHALL assert busy from edge 0 through the cycle before edge 17.
REQ-027 SHALL ignore start while busy is high, including at edge 17; the next start is accepted from edge 18.
REQ-028 SHALL drive rom_rd=0 and hold rom_addr at its last value in IDLE and COMMIT.
REQ-029 SHALL compute addresses without overflow; the maximum legal address is 1007.

Reset
REQ-030 SHALL on reset set wall_flags to 16'hFFFF, busy 0, done 0, rom_rd 0, rom_addr 0, state IDLE.
REQ-031 SHALL, on reset during a scan, abort the scan with no wall_flags update and no done pulse.
REQ-032 SHALL accept a start on the first edge after reset deasserts.

Verification
REQ-033 Ghost 0 at (13,16), ROM all-open except (13,17) wall; start -> after edge 17, wall_flags[3:0]=4'b0010, done pulses once, rom_rd low in the cycle after edge 17.
REQ-034 Ghost 1 at (0,19) and ghost 2 at (27,5) -> left flag of ghost 1 = 0, right flag of ghost 2 = 1, rom_rd=0 during lookups 6 and 11.
REQ-035 Ghost 3 at (13,16) with ROM wall at (13,15) -> up flag (bit 12) = 0; ghost 3 at (13,14) -> down flag (bit 13) = 1.
REQ-036 Ghost 0 at (40,2) -> wall_flags[3:0]=4'hF, no rom_rd during lookups 0-3.
REQ-037 start asserted again at edges 5 and 17 -> ignored, single done; start at edge 18 -> new scan, done after edge 35.
REQ-038 reset asserted at edge 8 of a scan -> wall_flags=16'hFFFF, no done, busy 0; subsequent start completes normally.
